mem_arbiter: RTL and testbench

Shares the core's single memory bus between the instruction-fetch port and the data port (loads, stores, fences from decode). Each port carries at most one request, buffered in a one-entry slot. Exactly one bus transaction is outstanding at a time. Data wins by default, and a starvation counter guarantees fetch progress. Sits between the fetch/decode stages and the memory/bus adapter, using the shared `mem_in_type`/`mem_out_type` records.

---
 rtl/constants.sv | 12 +
 rtl/wires.sv | 18 +
 rtl/mem_req_slot.sv | 31 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/constants.sv
// Core-wide constants and small shared enums.
package constants;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_type;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/wires.sv
// Shared memory-bus records used between the core stages and the bus adapter.
package wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request buffer: holds a request that could not be issued on arrival.
module mem_req_slot
  import wires::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       capture,
  input  logic       clear,
  input  mem_in_type req,
  output logic       valid,
  output mem_in_type data
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end
  end

  // An occupied slot ignores new pulses so the original request is kept.
  always_ff @(posedge clock) begin
    if (capture && !valid) begin
      data <= req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the data port,
// one outstanding transaction, data-first with a starvation guard for fetch.
module mem_arbiter
  import wires::*;
  import constants::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  bus_out,
  input  mem_out_type bus_in
);

  arb_state_type state;
  arb_state_type state_next;

  logic       ipend_valid;
  logic       dpend_valid;
  mem_in_type ipend_data;
  mem_in_type dpend_data;

  mem_in_type i_cand;
  mem_in_type d_cand;
  logic       i_cand_vld;
  logic       d_cand_vld;
  logic       can_issue;
  logic       i_issue;
  logic       d_issue;
  logic       i_capture;
  logic       d_capture;
  logic       starved;

  logic [3:0] starve_cnt;

  mem_req_slot u_islot (
    .clock   (clock),
    .reset   (reset),
    .capture (i_capture),
    .clear   (i_issue),
    .req     (imem_in),
    .valid   (ipend_valid),
    .data    (ipend_data)
  );

  mem_req_slot u_dslot (
    .clock   (clock),
    .reset   (reset),
    .capture (d_capture),
    .clear   (d_issue),
    .req     (dmem_in),
    .valid   (dpend_valid),
    .data    (dpend_data)
  );

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Issue happens in IDLE or in the response cycle, giving zero-cycle turnaround.
  always_comb begin
    i_cand     = ipend_valid ? ipend_data : imem_in;
    d_cand     = dpend_valid ? dpend_data : dmem_in;
    i_cand_vld = ipend_valid | imem_in.mem_valid;
    d_cand_vld = dpend_valid | dmem_in.mem_valid;
    can_issue  = reset & ((state == IDLE) | bus_in.mem_ready);
    i_issue    = can_issue & i_cand_vld & (~d_cand_vld | starved);
    d_issue    = can_issue & d_cand_vld & ~i_issue;
    bus_out    = '0;
    state_next = state;
    if (i_issue) begin
      bus_out           = i_cand;
      bus_out.mem_valid = 1'b1;
      state_next        = BUSY_I;
    end else if (d_issue) begin
      bus_out           = d_cand;
      bus_out.mem_valid = 1'b1;
      state_next        = BUSY_D;
    end else if (bus_in.mem_ready) begin
      state_next = IDLE;
    end
  end

  // A live request that is issued straight away never occupies its slot.
  assign i_capture = imem_in.mem_valid & ~(i_issue & ~ipend_valid);
  assign d_capture = dmem_in.mem_valid & ~(d_issue & ~dpend_valid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (i_issue) begin
      starve_cnt <= '0;
    end else if (d_issue && i_cand_vld && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    imem_out.mem_ready = bus_in.mem_ready & (state == BUSY_I);
    imem_out.mem_rdata = bus_in.mem_rdata;
    dmem_out.mem_ready = bus_in.mem_ready & (state == BUSY_D);
    dmem_out.mem_rdata = bus_in.mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_LIMIT=2; the bench acts as the memory.
module tb_mem_arbiter;
  import wires::*;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  bus_out;
  mem_out_type bus_in;

  int n_checks;
  int n_errors;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .bus_out  (bus_out),
    .bus_in   (bus_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requesters must never pulse a port whose slot is still occupied.
  always @(negedge clock) begin
    if (reset) begin
      assert (!(imem_in.mem_valid && dut.ipend_valid)) else $error("fetch pulse into occupied slot");
      assert (!(dmem_in.mem_valid && dut.dpend_valid)) else $error("data pulse into occupied slot");
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    imem_in = '0;
    dmem_in = '0;
    bus_in  = '0;
  endtask

  function automatic mem_in_type mk_req(input logic fence, input logic instr,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] wstrb);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  task automatic respond(input logic [31:0] rdata);
    bus_in.mem_ready = 1'b1;
    bus_in.mem_rdata = rdata;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    imem_in  = '0;
    dmem_in  = '0;
    bus_in   = '0;
    cyc();
    cyc();

    // reset state
    respond(32'h1234_5678);
    #1;
    check_eq("rst_bus_out", bus_out, '0);
    check_eq("rst_iready", imem_out.mem_ready, 0);
    check_eq("rst_dready", dmem_out.mem_ready, 0);
    reset = 1'b1;
    cyc();

    // idle fetch, ready three cycles later
    imem_in = mk_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    #1;
    check_eq("t1_valid", bus_out.mem_valid, 1);
    check_eq("t1_addr", bus_out.mem_addr, 32'h100);
    check_eq("t1_instr", bus_out.mem_instr, 1);
    cyc();
    cyc();
    cyc();
    respond(32'hDEAD_BEEF);
    #1;
    check_eq("t1_iready", imem_out.mem_ready, 1);
    check_eq("t1_dready", dmem_out.mem_ready, 0);
    check_eq("t1_irdata", imem_out.mem_rdata, 32'hDEAD_BEEF);
    check_eq("t1_bus_idle", bus_out.mem_valid, 0);
    cyc();

    // simultaneous fetch and load: load first, fetch on load's ready
    imem_in = mk_req(1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'h8000, 32'h0, 4'h0);
    #1;
    check_eq("t2_addr_load", bus_out.mem_addr, 32'h8000);
    check_eq("t2_instr_load", bus_out.mem_instr, 0);
    cyc();
    check_eq("t2_hold", bus_out.mem_valid, 0);
    respond(32'h11);
    #1;
    check_eq("t2_dready", dmem_out.mem_ready, 1);
    check_eq("t2_iready", imem_out.mem_ready, 0);
    check_eq("t2_drdata", dmem_out.mem_rdata, 32'h11);
    check_eq("t2_fetch_valid", bus_out.mem_valid, 1);
    check_eq("t2_fetch_addr", bus_out.mem_addr, 32'h200);
    cyc();
    respond(32'h22);
    #1;
    check_eq("t2_iready2", imem_out.mem_ready, 1);
    check_eq("t2_bus_idle", bus_out.mem_valid, 0);
    cyc();

    // store outstanding, fetch and load arrive while busy
    dmem_in = mk_req(1'b0, 1'b0, 32'h8004, 32'hCAFE, 4'hF);
    #1;
    check_eq("t3_st_addr", bus_out.mem_addr, 32'h8004);
    check_eq("t3_st_wstrb", bus_out.mem_wstrb, 4'hF);
    check_eq("t3_st_wdata", bus_out.mem_wdata, 32'hCAFE);
    cyc();
    imem_in = mk_req(1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'h8008, 32'h0, 4'h0);
    #1;
    check_eq("t3_busy_hold", bus_out.mem_valid, 0);
    cyc();
    respond(32'h33);
    #1;
    check_eq("t3_st_ready", dmem_out.mem_ready, 1);
    check_eq("t3_ld_addr", bus_out.mem_addr, 32'h8008);
    check_eq("t3_ld_valid", bus_out.mem_valid, 1);
    cyc();
    respond(32'h44);
    #1;
    check_eq("t3_ld_ready", dmem_out.mem_ready, 1);
    check_eq("t3_fetch_addr", bus_out.mem_addr, 32'h300);
    check_eq("t3_fetch_instr", bus_out.mem_instr, 1);
    cyc();
    respond(32'h55);
    #1;
    check_eq("t3_iready", imem_out.mem_ready, 1);
    cyc();

    // starvation guard: two data issues, then fetch forced
    imem_in = mk_req(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'h9000, 32'h0, 4'h0);
    #1;
    check_eq("t4_d1_addr", bus_out.mem_addr, 32'h9000);
    cyc();
    respond(32'h66);
    dmem_in = mk_req(1'b0, 1'b0, 32'h9004, 32'h0, 4'h0);
    #1;
    check_eq("t4_d2_addr", bus_out.mem_addr, 32'h9004);
    cyc();
    respond(32'h77);
    dmem_in = mk_req(1'b0, 1'b0, 32'h9008, 32'h0, 4'h0);
    #1;
    check_eq("t4_dready", dmem_out.mem_ready, 1);
    check_eq("t4_forced_addr", bus_out.mem_addr, 32'h400);
    check_eq("t4_forced_instr", bus_out.mem_instr, 1);
    cyc();
    respond(32'h88);
    #1;
    check_eq("t4_iready", imem_out.mem_ready, 1);
    check_eq("t4_dpend_addr", bus_out.mem_addr, 32'h9008);
    cyc();
    // counter cleared: data wins a fresh tie again
    respond(32'h99);
    imem_in = mk_req(1'b0, 1'b1, 32'h410, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'h900C, 32'h0, 4'h0);
    #1;
    check_eq("t4_cnt_clr_addr", bus_out.mem_addr, 32'h900C);
    cyc();
    respond(32'hAA);
    #1;
    check_eq("t4_fetch2_addr", bus_out.mem_addr, 32'h410);
    cyc();
    respond(32'hBB);
    #1;
    check_eq("t4_iready2", imem_out.mem_ready, 1);
    cyc();

    // fence behind an outstanding fetch
    imem_in = mk_req(1'b0, 1'b1, 32'h500, 32'h0, 4'h0);
    #1;
    check_eq("t5_fetch_addr", bus_out.mem_addr, 32'h500);
    cyc();
    dmem_in = mk_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check_eq("t5_fence_wait", bus_out.mem_valid, 0);
    cyc();
    cyc();
    respond(32'hCC);
    #1;
    check_eq("t5_iready", imem_out.mem_ready, 1);
    check_eq("t5_dready_no", dmem_out.mem_ready, 0);
    check_eq("t5_fence_valid", bus_out.mem_valid, 1);
    check_eq("t5_fence_bit", bus_out.mem_fence, 1);
    check_eq("t5_fence_wstrb", bus_out.mem_wstrb, 4'h0);
    cyc();
    respond(32'hDD);
    #1;
    check_eq("t5_fence_done", dmem_out.mem_ready, 1);
    check_eq("t5_iready_no", imem_out.mem_ready, 0);
    cyc();

    // reset while BUSY_D with a pending fetch
    imem_in = mk_req(1'b0, 1'b1, 32'h600, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 32'hA000, 32'h0, 4'h0);
    #1;
    check_eq("t6_load_addr", bus_out.mem_addr, 32'hA000);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    respond(32'hEE);
    #1;
    check_eq("t6_bus_valid", bus_out.mem_valid, 0);
    check_eq("t6_bus_zero", bus_out, '0);
    check_eq("t6_iready", imem_out.mem_ready, 0);
    check_eq("t6_dready", dmem_out.mem_ready, 0);
    cyc();
    imem_in = mk_req(1'b0, 1'b1, 32'h700, 32'h0, 4'h0);
    #1;
    check_eq("t6_post_valid", bus_out.mem_valid, 1);
    check_eq("t6_post_addr", bus_out.mem_addr, 32'h700);
    cyc();
    respond(32'hFF);
    #1;
    check_eq("t6_post_iready", imem_out.mem_ready, 1);
    check_eq("t6_post_rdata", imem_out.mem_rdata, 32'hFF);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
